// File: rtl/dff_pipe.sv
// dff_pipe: elastic register pipeline of DEPTH stages with valid/ready
// flow control, bubble collapsing, synchronous flush and occupancy count.
// Ports:
//   clk      - rising-edge clock
//   rst      - asynchronous active-high reset
//   flush    - synchronous clear of all stage valid bits
//   d        - input data word
//   d_valid  - d holds a word to transfer
//   d_ready  - pipeline accepts d this cycle
//   q        - data register of the last stage
//   q_valid  - q holds a valid word
//   q_ready  - consumer accepts q this cycle
//   count    - number of valid stages
module dff_pipe #(
   parameter int unsigned      WIDTH     = 8,
   parameter int unsigned      DEPTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           d,
   input  logic                       d_valid,
   output logic                       d_ready,
   output logic [WIDTH-1:0]           q,
   output logic                       q_valid,
   input  logic                       q_ready,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] v_q;
   logic [DEPTH-1:0] v_d;
   logic [WIDTH-1:0] data_q [DEPTH];
   logic [WIDTH-1:0] data_d [DEPTH];
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;

   logic             d_ready_c;
   logic             q_valid_c;

   always_comb begin : next_c
      // r[i]: stage i can take a word this cycle; r[DEPTH] is the consumer
      logic [DEPTH:0] r;
      logic [DEPTH-1:0] adv;
      // up_v / up_data: valid and data offered to stage i from upstream
      logic [DEPTH:0] up_v;
      logic [WIDTH-1:0] up_data [DEPTH+1];
      logic in_x;
      logic out_x;

      r = '0;
      adv = '0;
      r[DEPTH] = q_ready;
      // Ready ripples from the output back to the input so a stage that
      // empties this cycle can be refilled in the same cycle.
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
         adv[i] = v_q[i] & r[i+1];
         r[i] = ~v_q[i] | adv[i];
      end

      up_v = {v_q, d_valid};
      up_data[0] = d;
      for (int i = 0; i < int'(DEPTH); i++) begin
         up_data[i+1] = data_q[i];
      end

      d_ready_c = r[0] & ~flush & ~rst;
      q_valid_c = v_q[DEPTH-1] & ~flush;

      in_x = d_valid & d_ready_c;
      out_x = q_valid_c & q_ready;

      v_d = v_q;
      data_d = data_q;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (r[i] & up_v[i]) begin
            v_d[i] = 1'b1;
            data_d[i] = up_data[i];
         end else if (adv[i]) begin
            v_d[i] = 1'b0;
         end
      end

      count_d = count_q;
      unique case ({in_x, out_x})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      // Flush drops every word in flight but leaves stored data alone.
      if (flush) begin
         v_d = '0;
         data_d = data_q;
         count_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q <= '0;
         count_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            data_q[i] <= RESET_VAL;
         end
      end else begin
         v_q <= v_d;
         count_q <= count_d;
         for (int i = 0; i < int'(DEPTH); i++) begin
            data_q[i] <= data_d[i];
         end
      end
   end

   assign d_ready = d_ready_c;
   assign q_valid = q_valid_c;
   assign q = data_q[DEPTH-1];
   assign count = count_q;

endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: directed bench for dff_pipe (WIDTH=8, DEPTH=4) with a
// queue scoreboard filled on input transfers and drained on output ones.
module tb_dff_pipe;

   localparam int W = 8;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         flush = 1'b0;
   logic [W-1:0] d = '0;
   logic         d_valid = 1'b0;
   logic         d_ready;
   logic [W-1:0] q;
   logic         q_valid;
   logic         q_ready = 1'b0;
   logic [2:0]   count;

   dff_pipe #(
      .WIDTH(W),
      .DEPTH(D),
      .RESET_VAL(8'h00)
   ) dut (
      .clk(clk),
      .rst(rst),
      .flush(flush),
      .d(d),
      .d_valid(d_valid),
      .d_ready(d_ready),
      .q(q),
      .q_valid(q_valid),
      .q_ready(q_ready),
      .count(count)
   );

   always #5 clk = ~clk;

   int           n_assert = 0;
   int           n_fail = 0;
   int           cyc = 0;
   int           mcount = 0;
   int           first_acc = -1;
   int           first_out = -1;
   int           last_out_cyc = -1;
   int           n_out = 0;
   int           j = 0;
   bit           last_in;
   bit           last_out;
   logic [W-1:0] sb [$];

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_track();
      first_acc = -1;
      first_out = -1;
      last_out_cyc = -1;
      n_out = 0;
   endtask

   // One clock: sample handshakes at negedge, score, then check count
   // just after the rising edge.
   task automatic cycle();
      logic [W-1:0] e;
      @(negedge clk);
      last_in = d_valid && d_ready;
      last_out = q_valid && q_ready;
      if (last_out) begin
         chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("q_data", 64'(q), 64'(e));
         end
         if (first_out < 0) first_out = cyc;
         last_out_cyc = cyc;
         n_out++;
      end
      if (last_in) begin
         sb.push_back(d);
         if (first_acc < 0) first_acc = cyc;
      end
      if (flush) begin
         mcount = 0;
         sb.delete();
      end else begin
         mcount = mcount + int'(last_in) - int'(last_out);
      end
      @(posedge clk);
      #1;
      cyc++;
      chk("count", 64'(count), 64'(mcount));
   endtask

   task automatic drain();
      d_valid = 1'b0;
      q_ready = 1'b1;
      for (int k = 0; k < 20 && sb.size() != 0; k++) cycle();
      chk("drain_done", 64'(sb.size()), 64'd0);
      chk("drain_count", 64'(count), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      #1;
      chk("rst_q", 64'(q), 64'h00);
      chk("rst_q_valid", 64'(q_valid), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_d_ready", 64'(d_ready), 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("post_rst_d_ready", 64'(d_ready), 64'd1);

      // streaming 0x01..0x08, q_ready held high
      clear_track();
      q_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         d = 8'(i);
         d_valid = 1'b1;
         cycle();
         chk("stream_accept", 64'(last_in), 64'd1);
      end
      drain();
      chk("stream_latency", 64'(first_out - first_acc), 64'd4);
      chk("stream_no_gaps", 64'(last_out_cyc - first_out), 64'd7);
      chk("stream_n_out", 64'(n_out), 64'd8);

      // stalled consumer while sending 0x10..0x15
      q_ready = 1'b0;
      j = 0;
      for (int k = 0; k < 8; k++) begin
         d = 8'h10 + 8'(j);
         d_valid = 1'b1;
         cycle();
         if (last_in) j++;
         if (k >= 4) chk("stall_hold_q", 64'(q), 64'h10);
      end
      chk("stall_accepted", 64'(j), 64'd4);
      chk("stall_d_ready", 64'(d_ready), 64'd0);
      chk("stall_count", 64'(count), 64'd4);
      chk("stall_q_valid", 64'(q_valid), 64'd1);
      q_ready = 1'b1;
      for (int k = 0; k < 10 && j < 6; k++) begin
         d = 8'h10 + 8'(j);
         d_valid = 1'b1;
         cycle();
         if (last_in) j++;
      end
      chk("stall_sent_all", 64'(j), 64'd6);
      drain();

      // bubble collapse: d_valid 1,0,1,0 with q_ready low
      q_ready = 1'b0;
      d = 8'h21; d_valid = 1'b1; cycle();
      d = 8'hEE; d_valid = 1'b0; cycle();
      d = 8'h22; d_valid = 1'b1; cycle();
      d = 8'hEE; d_valid = 1'b0; cycle();
      repeat (3) cycle();
      chk("pack_count", 64'(count), 64'd2);
      chk("pack_q_valid", 64'(q_valid), 64'd1);
      chk("pack_q", 64'(q), 64'h21);
      q_ready = 1'b1;
      cycle();
      q_ready = 1'b0;
      chk("pack_next_valid", 64'(q_valid), 64'd1);
      chk("pack_next_q", 64'(q), 64'h22);
      drain();

      // full pipe with simultaneous input and output
      q_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         d = 8'h31 + 8'(i);
         d_valid = 1'b1;
         cycle();
      end
      chk("full_count0", 64'(count), 64'd4);
      q_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         d = 8'h35 + 8'(i);
         d_valid = 1'b1;
         cycle();
         chk("full_in", 64'(last_in), 64'd1);
         chk("full_out", 64'(last_out), 64'd1);
         chk("full_count", 64'(count), 64'd4);
      end
      drain();

      // flush with three words held and d_valid high
      q_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         d = 8'h41 + 8'(i);
         d_valid = 1'b1;
         cycle();
      end
      chk("flush_pre_count", 64'(count), 64'd3);
      flush = 1'b1;
      d = 8'h44;
      d_valid = 1'b1;
      #1;
      chk("flush_d_ready", 64'(d_ready), 64'd0);
      chk("flush_q_valid", 64'(q_valid), 64'd0);
      cycle();
      flush = 1'b0;
      d_valid = 1'b0;
      chk("flush_count", 64'(count), 64'd0);
      chk("flush_post_q_valid", 64'(q_valid), 64'd0);
      clear_track();
      q_ready = 1'b1;
      repeat (6) cycle();
      chk("flush_no_emit", 64'(n_out), 64'd0);
      d = 8'h50;
      d_valid = 1'b1;
      cycle();
      drain();

      // asynchronous reset pulse in mid-cycle with words in flight
      q_ready = 1'b0;
      d = 8'h61; d_valid = 1'b1; cycle();
      d = 8'h62; d_valid = 1'b1; cycle();
      d_valid = 1'b0;
      #3;
      rst = 1'b1;
      #1;
      chk("arst_q", 64'(q), 64'h00);
      chk("arst_q_valid", 64'(q_valid), 64'd0);
      chk("arst_count", 64'(count), 64'd0);
      chk("arst_d_ready", 64'(d_ready), 64'd0);
      sb.delete();
      mcount = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("arst_release_d_ready", 64'(d_ready), 64'd1);
      clear_track();
      q_ready = 1'b1;
      repeat (6) cycle();
      chk("arst_discard", 64'(n_out), 64'd0);
      d = 8'h70;
      d_valid = 1'b1;
      cycle();
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/dff_pipe.md
DFF_PIPE -- requirements
Module: dff_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per word (legal 1..64).
REQ-002 SHALL have parameter DEPTH, default 4, number of register stages (legal 1..16).
REQ-003 SHALL have parameter RESET_VAL, default 0, WIDTH-bit value loaded into every stage data register on reset.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous assert, active-high.
REQ-006 SHALL have port flush  input  1  synchronous clear of all stage valid bits.
REQ-007 SHALL have port d  input  WIDTH  input data word.
REQ-008 SHALL have port d_valid  input  1  d holds a word to transfer.
REQ-009 SHALL have port d_ready  output  1  pipeline accepts d this cycle.
REQ-010 SHALL have port q  output  WIDTH  data register of last stage (stage DEPTH-1).
REQ-011 SHALL have port q_valid  output  1  q holds a valid word.
REQ-012 SHALL have port q_ready  input  1  consumer accepts q this cycle.
REQ-013 SHALL have port count  output  $clog2(DEPTH+1)  number of valid stages.

Function
REQ-014 SHALL treat a transfer as valid&ready high at a rising clk edge, on both input and output sides.
REQ-015 SHALL hold per stage i a data register and a valid bit v[i]; stage 0 faces d, stage DEPTH-1 drives q and q_valid=v[DEPTH-1] (forced 0 while flush=1).
REQ-016 SHALL define adv[i] = v[i] & rdy_next, where rdy_next = q_ready for the last stage and r[i+1] otherwise; r[i] = ~v[i] | adv[i].
REQ-017 SHALL drive d_ready = r[0] & ~flush (combinational path through the chain is permitted).
REQ-018 SHALL load stage i data from stage i-1 (or d for stage 0) when r[i] and the upstream valid are high, setting v[i]=1; otherwise SHALL set v[i]=0 on adv[i] and hold data unchanged.
REQ-019 SHALL collapse bubbles: an empty stage accepts from upstream even when downstream is stalled.
REQ-020 SHALL give latency DEPTH cycles from input transfer to q_valid with q_ready held 1, and throughput one word per cycle.
REQ-021 SHALL preserve word order; no word lost or duplicated under any d_valid/q_ready pattern.
REQ-022 SHALL, with all stages full and q_ready=0, hold all data, keep d_ready=0, and keep count=DEPTH.
REQ-023 SHALL, with all stages full and q_ready=1, accept a new word the same cycle (d_ready=1).
REQ-024 SHALL update count: +1 on input transfer only, -1 on output transfer only, unchanged when both or neither occur.
REQ-025 SHALL, on flush=1, clear all v[i] and count to 0 at the next edge, perform no input or output transfer that cycle, and leave data registers unchanged.
REQ-026 SHALL ignore d contents when d_valid=0 and SHALL not change q while q_valid=1 and q_ready=0.

Reset
REQ-027 SHALL, on rst=1, immediately (without clk) clear all v[i], set count=0, q_valid=0, d_ready=0, and load all data registers with RESET_VAL, so q=RESET_VAL.
REQ-028 SHALL drive d_ready=1 (if flush=0) from the first cycle after rst deasserts; words in flight at reset assertion are discarded.

Verification
REQ-029 SHALL cover, with WIDTH=8, DEPTH=4: rst pulse mid-cycle -> q=0x00, q_valid=0, count=0 before next clk edge.
REQ-030 SHALL cover streaming 0x01..0x08 with q_ready=1 -> q_valid at cycle 4 after the first accept, q sequence 0x01..0x08 with no gaps.
REQ-031 SHALL cover q_ready=0 while sending 0x10..0x15 -> exactly 4 accepted, d_ready=0, count=4; q_ready=1 -> 0x10..0x15 delivered in order.
REQ-032 SHALL cover pattern d_valid 1,0,1,0 with q_ready=0 -> two words pack into stages 3 and 2, count=2.
REQ-033 SHALL cover full pipe with d_valid=1 and q_ready=1 simultaneously -> count stays 4, one word out and one in per cycle.
REQ-034 SHALL cover flush with count=3 and d_valid=1 -> next cycle count=0, q_valid=0, flushed word not later emitted.
